seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an NUM_DIGITS common-anode 7-seg display.
//  Latches a hex word, presents one nibble at a time to the shared hex-to-7-seg
//  decoder, registers its active-high segment pattern and drives active-low
//  anodes/cathodes. Sits between the CPU debug/result bus and the board display pins.
// PARAMETERS
//  NUM_DIGITS    8       digits scanned (1..16)
//  REFRESH_DIV   100000  clk cycles per digit slot (>= BLANK_CYCLES+1)
//  BLANK_CYCLES  4       cycles at slot start with all anodes off (anti-ghost, 0 allowed)
// PORTS
//  clk         in   1              system clock, rising edge
//  rst_n       in   1              async reset, active low
//  value_in    in   4*NUM_DIGITS   hex word; nibble k -> digit k (digit 0 = rightmost)
//  load        in   1              capture value_in/dp_in into shadow regs
//  digit_en    in   NUM_DIGITS     per-digit enable (1 = displayed), sampled live
//  dp_in       in   NUM_DIGITS     decimal point per digit, active high
//  nibble_out  out  4              to decoder b_in = shadow nibble[digit_idx] (combinational)
//  seg_in      in   7              from decoder, active high {g,f,e,d,c,b,a}
//  an_n        out  NUM_DIGITS     anode drive, active low, registered
//  seg_n       out  7              cathodes = ~seg_in, registered
//  dp_n        out  1              decimal point cathode, active low, registered
//  digit_idx   out  $clog2(NUM_DIGITS) current slot index, registered
//  frame_tick  out  1              1-cycle pulse when digit_idx wraps to 0
// BEHAVIOUR
//  Reset (async): prescaler=0, digit_idx=0, shadow value/dp=0, an_n=all 1, seg_n=7'h7F,
//   dp_n=1, frame_tick=0. Reset mid-slot forces these immediately; scan restarts at slot 0.
//  Shadow: on edge with load=1, shadow<=value_in, dp<=dp_in; load held high = transparent
//   per cycle. New value reaches seg_n/an_n at the 2nd edge after load sampled.
//  Prescaler: counts 0..REFRESH_DIV-1; at terminal count -> 0 and digit_idx advances,
//   NUM_DIGITS-1 wraps to 0 with frame_tick=1 on that same cycle, else frame_tick=0.
//  Output register each cycle (uses prescaler/digit_idx as of that edge's next state):
//   blank = (prescaler < BLANK_CYCLES) | ~show[digit_idx];
//   an_n  = blank ? all 1 : ~(1 << digit_idx);
//   seg_n = blank ? 7'h7F : ~seg_in;  dp_n = blank ? 1 : ~dp[digit_idx].
//  show[k] = digit_en[k] (see CONFIGURATION). Disabled slots still consume REFRESH_DIV
//   cycles: constant per-digit duty, no scan-rate change with mask.
//  At most one an_n bit low in any cycle; never two consecutive slots without >=
//   BLANK_CYCLES all-off cycles between them (when BLANK_CYCLES>0).
//  digit_en / dp changes take effect next edge; no FSM beyond prescaler + index counter.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: show[k] = digit_en[k] & (k==0 | k<=H), H = index of
//   highest nonzero shadow nibble (all zero -> only digit 0 shown). Shadow nibbles only.
//  Not defined: show[k] = digit_en[k]; leading zeros displayed as "0".
// TESTING  (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless noted; decoder instantiated)
//  1 rst_n low 3 cycles, release -> an_n=4'hF, seg_n=7'h7F, dp_n=1, digit_idx 0,1,2,3,0
//    each held 8 cycles; frame_tick exactly one pulse per 32 cycles at 3->0.
//  2 load=1 value_in=16'h1234 digit_en=4'hF -> slot 0 non-blank cycles: nibble_out=4,
//    an_n=4'b1110, seg_n=7'b0011001; slot 2: nibble_out=2, an_n=4'b1011, seg_n=7'b0100100.
//  3 Every slot: prescaler 0-1 -> an_n=4'hF; 2-7 -> exactly one an_n bit low; with
//    BLANK_CYCLES=0 no all-off cycle with digit_en=4'hF.
//  4 digit_en=4'b0101, dp_in=4'b0001 -> slots 1,3 an_n=4'hF whole slot, idx still steps
//    every 8; slot 0 dp_n=0, slot 2 dp_n=1.
//  5 rst_n low at prescaler=5 of slot 2 -> same cycle (async) an_n=4'hF, seg_n=7'h7F,
//    shadow=0; after release slot 0 shows digit "0" (seg_n=7'b1000000).
//  6 value_in=16'h0030, digit_en=4'hF -> macro defined: slots 2,3 blank, slot 1 shows 3,
//    slot 0 shows 0; macro undefined: all four slots lit (0,3,0,0).

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : seven_seg_scan_ctrl
// Brief    : Multiplexed common-anode 7-segment scan controller. Optional
//            leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [4*NUM_DIGITS-1:0]                            value_in,
    input  logic                                               load,
    input  logic [NUM_DIGITS-1:0]                              digit_en,
    input  logic [NUM_DIGITS-1:0]                              dp_in,
    output logic [3:0]                                         nibble_out,
    input  logic [6:0]                                         seg_in,
    output logic [NUM_DIGITS-1:0]                              an_n,
    output logic [6:0]                                         seg_n,
    output logic                                               dp_n,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                                               frame_tick
);

    localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   c_PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IDXW-1:0] c_IDX_LAST   = IDXW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_presc;
    logic [IDXW-1:0]         r_idx;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_an_n;
    logic [6:0]              r_seg_n;
    logic                    r_dp_n;
    logic                    r_frame_tick;

    logic [PW-1:0]           w_presc_nxt;
    logic [IDXW-1:0]         w_idx_nxt;
    logic                    w_term;
    logic                    w_wrap;
    logic                    w_in_blank;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_show;
    logic [NUM_DIGITS-1:0]   w_an_on;
    logic [3:0]              w_nibs [NUM_DIGITS];

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_nib
            assign w_nibs[k] = r_value[4*k +: 4];
        end
    endgenerate

    assign nibble_out = w_nibs[r_idx];

    assign w_term      = (r_presc == c_PRESC_LAST);
    assign w_wrap      = w_term && (r_idx == c_IDX_LAST);
    assign w_presc_nxt = w_term ? '0 : r_presc + 1'b1;
    assign w_idx_nxt   = !w_term ? r_idx : (w_wrap ? '0 : r_idx + 1'b1);

    // The anti-ghost window is judged on the prescaler value entering this cycle.
    generate
        if (BLANK_CYCLES == 0) begin : g_blank_none
            assign w_in_blank = 1'b0;
        end else begin : g_blank_lead
            assign w_in_blank = (w_presc_nxt < PW'(BLANK_CYCLES));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    int w_hi;
    always_comb begin
        w_hi   = 0;
        w_show = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (w_nibs[d] != 4'h0) w_hi = d;
        end
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_show[d] = digit_en[d] & ((d == 0) | (d <= w_hi));
        end
    end
`else
    assign w_show = digit_en;
`endif

    assign w_blank = w_in_blank | ~w_show[w_idx_nxt];
    assign w_an_on = ~(NUM_DIGITS'(1) << w_idx_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_value      <= '0;
            r_dp         <= '0;
            r_an_n       <= '1;
            r_seg_n      <= 7'h7F;
            r_dp_n       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_idx        <= w_idx_nxt;
            r_frame_tick <= w_wrap;
            if (load) begin
                r_value <= value_in;
                r_dp    <= dp_in;
            end
            r_an_n  <= w_blank ? '1 : w_an_on;
            r_seg_n <= w_blank ? 7'h7F : ~seg_in;
            r_dp_n  <= w_blank ? 1'b1 : ~r_dp[w_idx_nxt];
        end
    end

    assign an_n       = r_an_n;
    assign seg_n      = r_seg_n;
    assign dp_n       = r_dp_n;
    assign digit_idx  = r_idx;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// ============================================================================
// Module   : tb_seven_seg_scan_ctrl
// Brief    : Directed self-checking bench for seven_seg_scan_ctrl (4 digits).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;

    logic [3:0]  nib,   nib0;
    logic [6:0]  seg_in, seg_in0;
    logic [3:0]  an_n,  an_n0;
    logic [6:0]  seg_n, seg_n0;
    logic        dp_n,  dp_n0;
    logic [1:0]  idx,   idx0;
    logic        ft,    ft0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
        endcase
    endfunction

    assign seg_in  = hex7(nib);
    assign seg_in0 = hex7(nib0);

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .digit_en(digit_en), .dp_in(dp_in), .nibble_out(nib), .seg_in(seg_in),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .digit_idx(idx), .frame_tick(ft)
    );

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load),
        .digit_en(digit_en), .dp_in(dp_in), .nibble_out(nib0), .seg_in(seg_in0),
        .an_n(an_n0), .seg_n(seg_n0), .dp_n(dp_n0), .digit_idx(idx0), .frame_tick(ft0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        logic [1:0] e_idx;
        do_reset();
        n_vec++; if (an_n !== 4'hF) begin n_err++; $display("FAIL rst_an: got %h want %h", an_n, 4'hF); end
        n_vec++; if (seg_n !== 7'h7F) begin n_err++; $display("FAIL rst_seg: got %h want %h", seg_n, 7'h7F); end
        n_vec++; if (dp_n !== 1'b1) begin n_err++; $display("FAIL rst_dp: got %b want 1", dp_n); end
        n_vec++; if (idx !== 2'd0) begin n_err++; $display("FAIL rst_idx: got %0d want 0", idx); end
        n_vec++; if (ft !== 1'b0) begin n_err++; $display("FAIL rst_ft: got %b want 0", ft); end
        for (int i = 0; i < 40; i++) begin
            tick();
            e_idx = 2'((cyc / 8) % 4);
            n_vec++; if (idx !== e_idx) begin n_err++; $display("FAIL step_idx c%0d: got %0d want %0d", cyc, idx, e_idx); end
            n_vec++; if (ft !== (cyc % 32 == 0)) begin n_err++; $display("FAIL step_ft c%0d: got %b want %b", cyc, ft, (cyc % 32 == 0)); end
        end
    endtask

    task automatic test_load_1234();
        value_in = 16'h1234; digit_en = 4'hF; dp_in = 4'h0; load = 1'b1;
        tick();
        load = 1'b0;
        do tick(); while (cyc % 32 != 2);
        n_vec++; if (nib !== 4'h4) begin n_err++; $display("FAIL s0_nib: got %h want 4", nib); end
        n_vec++; if (an_n !== 4'b1110) begin n_err++; $display("FAIL s0_an: got %b want 1110", an_n); end
        n_vec++; if (seg_n !== 7'b0011001) begin n_err++; $display("FAIL s0_seg: got %b want 0011001", seg_n); end
        n_vec++; if (dp_n !== 1'b1) begin n_err++; $display("FAIL s0_dp: got %b want 1", dp_n); end
        do tick(); while (cyc % 32 != 18);
        n_vec++; if (nib !== 4'h2) begin n_err++; $display("FAIL s2_nib: got %h want 2", nib); end
        n_vec++; if (an_n !== 4'b1011) begin n_err++; $display("FAIL s2_an: got %b want 1011", an_n); end
        n_vec++; if (seg_n !== 7'b0100100) begin n_err++; $display("FAIL s2_seg: got %b want 0100100", seg_n); end
    endtask

    task automatic test_scan();
        logic [1:0] e_idx;
        logic [3:0] e_on;
        for (int i = 0; i < 64; i++) begin
            tick();
            e_idx = 2'((cyc / 8) % 4);
            e_on  = 4'hF ^ (4'b0001 << e_idx);
            n_vec++; if (an_n !== ((cyc % 8 < 2) ? 4'hF : e_on)) begin
                n_err++; $display("FAIL scan_an c%0d: got %b want %b", cyc, an_n, (cyc % 8 < 2) ? 4'hF : e_on); end
            n_vec++; if (an_n0 !== e_on) begin n_err++; $display("FAIL scan_an_b0 c%0d: got %b want %b", cyc, an_n0, e_on); end
            n_vec++; if (ft !== (cyc % 32 == 0)) begin n_err++; $display("FAIL scan_ft c%0d: got %b want %b", cyc, ft, (cyc % 32 == 0)); end
        end
    endtask

    task automatic test_mask();
        logic [1:0] e_idx;
        logic [3:0] e_an;
        logic       e_dp;
        digit_en = 4'b0101; dp_in = 4'b0001; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            e_idx = 2'((cyc / 8) % 4);
            e_an  = 4'hF;
            e_dp  = 1'b1;
            if (cyc % 8 >= 2 && e_idx == 2'd0) begin e_an = 4'b1110; e_dp = 1'b0; end
            if (cyc % 8 >= 2 && e_idx == 2'd2) e_an = 4'b1011;
            n_vec++; if (idx !== e_idx) begin n_err++; $display("FAIL mask_idx c%0d: got %0d want %0d", cyc, idx, e_idx); end
            n_vec++; if (an_n !== e_an) begin n_err++; $display("FAIL mask_an c%0d: got %b want %b", cyc, an_n, e_an); end
            n_vec++; if (dp_n !== e_dp) begin n_err++; $display("FAIL mask_dp c%0d: got %b want %b", cyc, dp_n, e_dp); end
        end
    endtask

    task automatic test_async_reset();
        digit_en = 4'hF; dp_in = 4'h0;
        do tick(); while (cyc % 32 != 21);
        n_vec++; if (an_n !== 4'b1011) begin n_err++; $display("FAIL pre_ar_an: got %b want 1011", an_n); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (an_n !== 4'hF) begin n_err++; $display("FAIL ar_an: got %b want 1111", an_n); end
        n_vec++; if (seg_n !== 7'h7F) begin n_err++; $display("FAIL ar_seg: got %h want 7f", seg_n); end
        n_vec++; if (dp_n !== 1'b1) begin n_err++; $display("FAIL ar_dp: got %b want 1", dp_n); end
        n_vec++; if (idx !== 2'd0) begin n_err++; $display("FAIL ar_idx: got %0d want 0", idx); end
        n_vec++; if (nib !== 4'h0) begin n_err++; $display("FAIL ar_shadow: got %h want 0", nib); end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        tick();
        n_vec++; if (an_n !== 4'b1110) begin n_err++; $display("FAIL post_ar_an: got %b want 1110", an_n); end
        n_vec++; if (seg_n !== 7'b1000000) begin n_err++; $display("FAIL post_ar_seg: got %b want 1000000", seg_n); end
    endtask

    task automatic test_lzb();
        logic [1:0] e_idx;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        value_in = 16'h0030; digit_en = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        do tick(); while (cyc % 32 != 0);
        for (int i = 0; i < 32; i++) begin
            tick();
            if (cyc % 8 >= 2) begin
                e_idx = 2'((cyc / 8) % 4);
                e_an  = 4'hF ^ (4'b0001 << e_idx);
                e_seg = (e_idx == 2'd1) ? 7'b0110000 : 7'b1000000;
`ifdef LEADING_ZERO_BLANK_EN
                if (e_idx >= 2'd2) begin e_an = 4'hF; e_seg = 7'h7F; end
`endif
                n_vec++; if (an_n !== e_an) begin n_err++; $display("FAIL lzb_an c%0d: got %b want %b", cyc, an_n, e_an); end
                n_vec++; if (seg_n !== e_seg) begin n_err++; $display("FAIL lzb_seg c%0d: got %b want %b", cyc, seg_n, e_seg); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1; value_in = '0; load = 1'b0; digit_en = 4'hF; dp_in = 4'h0;
        test_reset();
        test_load_1234();
        test_scan();
        test_mask();
        test_async_reset();
        test_lzb();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
